// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the instruction fetch unit.
//   WORD_W       : instruction / address width
//   INSTR_BYTES  : bytes per instruction (fetch_pc increment)
//   ifu_state_e  : fetch FSM states
//   fetch_entry_t: prefetch FIFO entry {pc, instr}
// -----------------------------------------------------------------------------
package ifu_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at the top of the address space.
  function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// ifu_prefetch_fifo
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk_i, rst_i        : clock, async active-high reset
//   flush_i             : synchronous flush (empties FIFO, dominates push/pop)
//   push_i / wdata_i    : write an entry (caller guarantees ~full or same-cycle pop)
//   pop_i               : drop the head entry
//   rdata_o             : head entry (storage-registered, holds when empty)
//   full_o / empty_o    : occupancy flags
// DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module ifu_prefetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t        mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q,  count_d;
  logic                wr_en_s;

  assign wr_en_s = push_i & ~flush_i;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign rdata_o = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy count; flush has priority.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      // Simultaneous push+pop leaves the count unchanged.
      if (push_i && !pop_i) begin
        count_d = count_q + CW'(1);
      end else if (pop_i && !push_i) begin
        count_d = count_q - CW'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; reset to zero so the head reads 0 out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch front end: drives imem_addr_o, captures the same-cycle
// instruction into a prefetch FIFO and hands entries to decode via valid/ready.
// Ports:
//   clk_i, rst_i            : clock, async active-high reset
//   fetch_en_i              : fetch permitted
//   imem_addr_o/imem_instr_i: instruction memory address / same-cycle data
//   instr_valid_o/ready_i   : decode handshake; instr_o/pc_o = FIFO head
//   redirect_i/redirect_pc_i: flush and restart at a new word-aligned PC
//   halt_o                  : fetch halted on a zero word
// Optional feature macro: IFU_ZERO_HALT_EN (halt fetch on a zero instruction
// word; when undefined, zero words are ordinary and halt_o is tied low).
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        halt_o
);

  ifu_state_e   state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         full_s, empty_s;
  logic         can_push_s, push_s, pop_s, zero_hit_s;
  fetch_entry_t wdata_s, rdata_s;
  logic [1:0]   unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc_i[1:0];

  assign imem_addr_o   = fetch_pc_q;
  // Redirect suppresses the handshake in the same cycle.
  assign instr_valid_o = ~empty_s & ~redirect_i;
  assign pop_s         = instr_valid_o & instr_ready_i;
  // A full FIFO still accepts a word when the head leaves this cycle.
  assign can_push_s    = (state_q == RUN) & fetch_en_i & ~redirect_i & (~full_s | pop_s);

`ifdef IFU_ZERO_HALT_EN
  assign zero_hit_s = can_push_s & (imem_instr_i == 32'h0000_0000);
  assign push_s     = can_push_s & ~zero_hit_s;
  assign halt_o     = (state_q == HALT);
`else
  assign zero_hit_s = 1'b0;
  assign push_s     = can_push_s;
  assign halt_o     = 1'b0;
`endif

  assign wdata_s = '{pc: fetch_pc_q, instr: imem_instr_i};
  assign instr_o = rdata_s.instr;
  assign pc_o    = rdata_s.pc;

  ifu_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wdata_s),
    .rdata_o (rdata_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Fetch FSM next state; redirect overrides every state.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      if (fetch_en_i) begin
        state_d = RUN;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en_i) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (!fetch_en_i) begin
            state_d = IDLE;
          end else if (zero_hit_s) begin
            state_d = HALT;
          end else begin
            state_d = RUN;
          end
        end
`ifdef IFU_ZERO_HALT_EN
        HALT: begin
          state_d = HALT;
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Next fetch address: redirect target, sequential on push, else hold.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (push_s) begin
      fetch_pc_d = next_pc(fetch_pc_q);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // State and fetch PC registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with a combinational memory model:
//   addr 0x0 -> 0x20080005, addr 0x4 -> 0x20090003,
//   otherwise {16'hC0DE, addr[15:0]}; with zero_mode set, addr 0x8 -> 0.
// Honors IFU_ZERO_HALT_EN for the zero-word scenario.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        zero_mode;

  int n_checks;
  int n_passed;

  instr_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_en_i    (fetch_en),
    .imem_addr_o   (imem_addr),
    .imem_instr_i  (imem_instr),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .pc_o          (pc),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .halt_o        (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic zm);
    logic [31:0] w;
    case (a)
      32'h0000_0000: w = 32'h2008_0005;
      32'h0000_0004: w = 32'h2009_0003;
      default:       w = {16'hC0DE, a[15:0]};
    endcase
    if (zm && a == 32'h0000_0008) w = 32'h0000_0000;
    return w;
  endfunction

  always_comb imem_instr = mem_word(imem_addr, zero_mode);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    n_checks    = 0;
    n_passed    = 0;
    rst         = 1'b1;
    fetch_en    = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    zero_mode   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc",    pc, 32'h0);
    check("rst_halt",  {31'd0, halt}, 32'd0);

    // Streaming: IDLE->RUN takes one edge, then one word per cycle
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    tick();
    check("run_addr0",  imem_addr, 32'h0);
    check("run_valid0", {31'd0, instr_valid}, 32'd0);
    tick();
    check("s0_valid", {31'd0, instr_valid}, 32'd1);
    check("s0_instr", instr, 32'h2008_0005);
    check("s0_pc",    pc, 32'h0);
    check("s0_addr",  imem_addr, 32'h4);
    tick();
    check("s1_instr", instr, 32'h2009_0003);
    check("s1_pc",    pc, 32'h4);
    tick();
    check("s2_instr", instr, 32'hC0DE_0008);
    check("s2_pc",    pc, 32'h8);
    check("s2_addr",  imem_addr, 32'hC);

    // Restart at 0 with backpressure: FIFO fills with 4 words
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    #1;
    check("rd0_valid_forced", {31'd0, instr_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("full_addr_hold", imem_addr, 32'h10);
    check("full_head_pc",   pc, 32'h0);
    instr_ready = 1'b1;
    exp_pc = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("drain_valid", {31'd0, instr_valid}, 32'd1);
      check("drain_pc",    pc, exp_pc);
      exp_pc = exp_pc + 32'd4;
      if (i < 4) tick();
    end
    check("drain_instr10", instr, 32'hC0DE_0010);

    // Redirect while FIFO holds 3 entries
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    instr_ready = 1'b0;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("three_addr", imem_addr, 32'h20C);
    check("three_pc",   pc, 32'h200);
    redirect    = 1'b1;
    redirect_pc = 32'h47;
    instr_ready = 1'b1;
    #1;
    check("rd_valid_forced", {31'd0, instr_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    check("rd_addr",  imem_addr, 32'h44);
    check("rd_empty", {31'd0, instr_valid}, 32'd0);
    tick();
    check("rd_valid", {31'd0, instr_valid}, 32'd1);
    check("rd_pc",    pc, 32'h44);
    check("rd_instr", instr, 32'hC0DE_0044);
    for (int i = 0; i < 3; i++) tick();
    check("pre_rst_addr", imem_addr, 32'h54);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_addr",  imem_addr, 32'h0);
    tick();
    rst = 1'b0;

    // Address wrap at the top of memory
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr0", imem_addr, 32'h0);
    check("wrap_pc",    pc, 32'hFFFF_FFFC);
    check("wrap_instr", instr, 32'hC0DE_FFFC);
    tick();
    check("wrap_pc0", pc, 32'h0);

    // Fetch disable: no new fetch, FIFO drains
    fetch_en = 1'b0;
    tick();
    check("dis_addr",  imem_addr, 32'h4);
    check("dis_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("dis_addr2", imem_addr, 32'h4);

    // Zero word at 0x8
    zero_mode   = 1'b1;
    fetch_en    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    check("z_addr0", imem_addr, 32'h0);
    tick();
    check("z_pc0", pc, 32'h0);
    tick();
    check("z_pc4", pc, 32'h4);
    tick();
`ifdef IFU_ZERO_HALT_EN
    check("z_valid", {31'd0, instr_valid}, 32'd0);
    check("z_halt",  {31'd0, halt}, 32'd1);
    check("z_addr",  imem_addr, 32'h8);
    tick();
    check("z_halt2", {31'd0, halt}, 32'd1);
    check("z_addr2", imem_addr, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    check("z_unhalt", {31'd0, halt}, 32'd0);
    check("z_raddr",  imem_addr, 32'h0);
    tick();
    check("z_restart_valid", {31'd0, instr_valid}, 32'd1);
    check("z_restart_pc",    pc, 32'h0);
`else
    check("z_valid", {31'd0, instr_valid}, 32'd1);
    check("z_pc8",   pc, 32'h8);
    check("z_instr", instr, 32'h0);
    check("z_halt",  {31'd0, halt}, 32'd0);
    check("z_addr",  imem_addr, 32'hC);
`endif

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: drives a word-aligned byte address each cycle and captures the 32-bit instruction returned combinationally in the same cycle.
- Buffers fetched words with their PCs in a small prefetch FIFO.
- Presents them to the decode stage over a valid/ready handshake.
- Supports redirect (branch/jump) with flush, and fetch enable/disable.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of 2, >= 2
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] must be 0

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- fetch_en_i  input  1  permits fetching when high
- imem_addr_o  output  32  byte address to instruction memory (= fetch_pc)
- imem_instr_i  input  32  instruction word for imem_addr_o, valid same cycle
- instr_valid_o  output  1  FIFO head valid
- instr_ready_i  input  1  consumer accepts head this cycle
- instr_o  output  32  instruction at FIFO head
- pc_o  output  32  PC of instruction at FIFO head
- redirect_i  input  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  input  32  new fetch address; bits [1:0] ignored (forced 0)
- halt_o  output  1  fetch halted (see Optional Feature)

Behaviour:
- Reset (async): fetch_pc=RESET_PC, FIFO empty, FSM=IDLE, instr_valid_o=0, instr_o=0, pc_o=0, halt_o=0.
- imem_addr_o = fetch_pc, combinational from the register, in every state.
- FSM states:
  - IDLE -> RUN when fetch_en_i=1.
  - RUN -> IDLE when fetch_en_i=0.
  - HALT (optional feature only) exits only via redirect_i or reset.
- push = (state==RUN) & fetch_en_i & ~redirect_i & (~full | pop).
  - On push: FIFO entry {fetch_pc, imem_instr_i} is written and fetch_pc <= fetch_pc+4.
  - fetch_pc wraps 32'hFFFF_FFFC -> 0.
- pop = instr_valid_o & instr_ready_i & ~redirect_i.
- Latency: a word pushed at edge N is visible on instr_o/pc_o with instr_valid_o=1 after edge N (one cycle from address to output). Steady state is 1 instruction/cycle with ready held high.
- Full:
  - Push is allowed only when a pop occurs in the same cycle; otherwise fetch_pc holds.
  - Count stays DEPTH on simultaneous push+pop.
- Empty: instr_valid_o=0; instr_o/pc_o hold their last values, with no requirement on contents.
- Redirect (highest priority):
  - At the edge: FIFO is flushed (count=0), fetch_pc <= {redirect_pc_i[31:2],2'b00}, no push, no pop. HALT -> RUN if fetch_en_i=1, else IDLE; halt_o <= 0.
  - During the redirect cycle, instr_valid_o is forced 0 combinationally.
  - The first redirected instruction appears 2 cycles after redirect_i asserts (fetched in the following cycle).
- fetch_en_i low: fetching stops, but the FIFO continues to drain.
- Count register width is $clog2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.
- No X propagation: all registers reset.

Optional Feature:
- Macro IFU_ZERO_HALT_EN.
- Defined:
  - When in RUN and a push would capture imem_instr_i==32'h0, that word is not pushed, fetch_pc holds, FSM -> HALT, and halt_o=1 from the next cycle.
  - This stops fetch at the zero-filled tail of instruction memory.
  - FIFO contents still drain in HALT.
- Undefined: zero words are ordinary instructions (MIPS nop), the HALT state is not built, and halt_o is tied 0.

Decomposition:
- Package ifu_pkg:
  - WORD_W=32, INSTR_BYTES=4.
  - State enum {IDLE, RUN, HALT}.
  - Typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module ifu_prefetch_fifo:
  - Parameterised DEPTH.
  - Ports push/pop/flush, full/empty, wdata/rdata of fetch_entry_t, synchronous flush.
- The top level holds the FSM, fetch_pc and the redirect/push/pop logic.

Test Plan:
- Reset, fetch_en_i=1, instr_ready_i=1, memory words 0x20080005,0x20090003,... -> imem_addr_o 0,4,8,...; instr_o 0x20080005 with pc_o=0 after first edge, then one instruction per cycle.
- instr_ready_i=0 for 8 cycles, DEPTH=4 -> 4 pushes then imem_addr_o holds at 0x10. Releasing ready yields pc_o 0,4,8,0xC,0x10 with no gap and no drop.
- Redirect to 0x47 while FIFO holds 3 entries -> instr_valid_o=0 that cycle, FIFO emptied, imem_addr_o=0x44 next cycle, pc_o=0x44 two cycles after redirect.
- rst_i pulsed mid-stream, asynchronously between edges -> instr_valid_o=0 and imem_addr_o=RESET_PC immediately, without waiting for a clock edge.
- fetch_pc at 0xFFFFFFFC with push -> next imem_addr_o=0x0.
- IFU_ZERO_HALT_EN defined, word at 0x8 is 0 -> pc_o 0,4 delivered, 0x8 never delivered, halt_o=1. A subsequent redirect to 0 clears halt_o and restarts fetch.
